// File: rtl/switch_input_conditioner_pkg.sv
// Shared constants and types for the switch input path: event FSM states and
// the divider/counter sizing helpers also used for other clock-rate constants.
package switch_input_conditioner_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StPend = 1'b1
  } evt_state_t;

  localparam int unsigned BoardClkHz           = 100_000_000;
  localparam int unsigned DefaultSampleHz      = 1_000;
  localparam int unsigned DefaultStableSamples = 16;

  // Clock cycles per debounce sample.
  function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                input int unsigned sample_hz);
    return clk_hz / sample_hz;
  endfunction

  // Counter must be able to hold STABLE_SAMPLES itself for the compare.
  function automatic int unsigned calc_cnt_width(input int unsigned stable_samples);
    return $clog2(stable_samples + 1);
  endfunction

  // Tick counter only needs to reach tick_div-1.
  function automatic int unsigned calc_tick_width(input int unsigned tick_div);
    return (tick_div < 2) ? 1 : $clog2(tick_div);
  endfunction

  localparam int unsigned DefaultTickDiv = calc_tick_div(BoardClkHz, DefaultSampleHz);
  localparam int unsigned DefaultCntW    = calc_cnt_width(DefaultStableSamples);

endpackage

// File: rtl/switch_input_conditioner_if.sv
// Change-event handshake between the switch conditioner and its consumer.
interface switch_input_conditioner_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_bits;
  logic [WIDTH-1:0] evt_mask;

  modport master (
    output evt_valid,
    output evt_bits,
    output evt_mask,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_bits,
    input  evt_mask,
    output evt_ready
  );

endinterface

// File: rtl/switch_input_conditioner_debounce_cell.sv
// One switch bit: 2-flop synchronizer, sample-rate debounce counter, clean
// level flop and registered rise/fall pulses aligned with the new level.
module switch_input_conditioner_debounce_cell
  import switch_input_conditioner_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = DefaultStableSamples,
  parameter int unsigned CNT_W          = calc_cnt_width(STABLE_SAMPLES),
  parameter logic        RESET_VAL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_tick,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntStable = CNT_W'(STABLE_SAMPLES);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             clean_q, clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  assign cnt_inc = cnt_q + CntOne;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive differing samples; any agreeing sample restarts the run.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sample_tick) begin
      if (sync2_q == clean_q) begin
        cnt_d = '0;
      end else if (cnt_inc == CntStable) begin
        cnt_d   = '0;
        clean_d = ~clean_q;
        rise_d  = ~clean_q;
        fall_d  = clean_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Pulses share the edge with the level flip so both show up together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clean_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

endmodule

// File: rtl/switch_input_conditioner.sv
// Board switch conditioner: per-bit debounce cells driven by a shared sample
// tick, plus a change-event FSM that accumulates edges until the consumer
// accepts them.
module switch_input_conditioner
  import switch_input_conditioner_pkg::*;
#(
  parameter int unsigned      WIDTH          = 8,
  parameter int unsigned      CLK_HZ         = BoardClkHz,
  parameter int unsigned      SAMPLE_HZ      = DefaultSampleHz,
  parameter int unsigned      STABLE_SAMPLES = DefaultStableSamples,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            sw_raw,
  output logic [WIDTH-1:0]            sw_clean,
  output logic [WIDTH-1:0]            sw_rise,
  output logic [WIDTH-1:0]            sw_fall,
  switch_input_conditioner_if.master  evt
);

  localparam int unsigned TICK_DIV = calc_tick_div(CLK_HZ, SAMPLE_HZ);
  localparam int unsigned TICK_W   = calc_tick_width(TICK_DIV);
  localparam int unsigned CNT_W    = calc_cnt_width(STABLE_SAMPLES);

  localparam logic [TICK_W-1:0] TickOne  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TickLast = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic              sample_tick;

  evt_state_t        state_q, state_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  bits_q, bits_d;
  logic [WIDTH-1:0]  edges;
  logic              any_edge;
  logic              accept;

  // Free-running sample divider; tick on the last count of each period.
  assign sample_tick = (tick_q == TickLast);

  always_comb begin
    tick_d = sample_tick ? '0 : tick_q + TickOne;
  end

  // Divider state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    switch_input_conditioner_debounce_cell #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .CNT_W          (CNT_W),
      .RESET_VAL      (RESET_VAL[i])
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_tick (sample_tick),
      .sw_raw      (sw_raw[i]),
      .sw_clean    (sw_clean[i]),
      .sw_rise     (sw_rise[i]),
      .sw_fall     (sw_fall[i])
    );
  end

  assign edges    = sw_rise | sw_fall;
  assign any_edge = |edges;
  assign accept   = (state_q == StPend) && evt.evt_ready;

  // Event FSM: merge edges while pending so a double toggle is never lost;
  // an edge arriving with the accept opens a fresh event at once.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    bits_d  = bits_q;
    case (state_q)
      StIdle: begin
        if (any_edge) begin
          state_d = StPend;
          mask_d  = edges;
          bits_d  = sw_clean;
        end
      end
      StPend: begin
        bits_d = sw_clean;
        if (accept) begin
          if (any_edge) begin
            mask_d = edges;
          end else begin
            state_d = StIdle;
            mask_d  = '0;
          end
        end else begin
          mask_d = mask_q | edges;
        end
      end
      default: begin
        state_d = StIdle;
        mask_d  = '0;
      end
    endcase
  end

  // Event FSM state and payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
      bits_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      bits_q  <= bits_d;
    end
  end

  assign evt.evt_valid = (state_q == StPend);
  assign evt.evt_bits  = bits_q;
  assign evt.evt_mask  = mask_q;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Directed bench for switch_input_conditioner with TICK_DIV=10, 4 stable samples.
// Edge pulses are checked against a scoreboard filled when stimulus is driven.
module tb_switch_input_conditioner;

  typedef struct packed {
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] clean;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw_raw;
  logic [7:0] sw_clean;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  switch_input_conditioner_if #(.WIDTH(8)) evt_bus ();

  switch_input_conditioner #(
    .WIDTH          (8),
    .CLK_HZ         (1000),
    .SAMPLE_HZ      (100),
    .STABLE_SAMPLES (4),
    .RESET_VAL      (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .evt      (evt_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts negedges until a pulse shows; bounded so a dead DUT still ends.
  task automatic wait_pulse(input string tag, input int lo, input int hi);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sw_rise | sw_fall) == 8'h00 && n < hi + 5);
    check_range(tag, n, lo, hi);
  endtask

  // Called on the pulse cycle: event appears next cycle, then a one-cycle accept.
  task automatic accept_event(input string tag, input logic [7:0] mask, input logic [7:0] bits);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, evt_bus.evt_valid}, 32'd1);
    check({tag, "_mask"}, {24'd0, evt_bus.evt_mask}, {24'd0, mask});
    check({tag, "_bits"}, {24'd0, evt_bus.evt_bits}, {24'd0, bits});
    evt_bus.evt_ready = 1'b1;
    @(negedge clk);
    evt_bus.evt_ready = 1'b0;
    check({tag, "_idle_valid"}, {31'd0, evt_bus.evt_valid}, 32'd0);
    check({tag, "_idle_mask"}, {24'd0, evt_bus.evt_mask}, 32'd0);
  endtask

  task automatic drive(input logic [7:0] raw, input logic [7:0] rise, input logic [7:0] fall);
    exp_t e;
    sw_raw  = raw;
    e.rise  = rise;
    e.fall  = fall;
    e.clean = raw;
    sb.push_back(e);
  endtask

  // Scoreboard: every pulse must match the oldest expected edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (sw_rise | sw_fall) !== 8'h00) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {16'd0, sw_rise, sw_fall}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_rise", {24'd0, sw_rise}, {24'd0, e.rise});
        check("sb_fall", {24'd0, sw_fall}, {24'd0, e.fall});
        check("sb_clean", {24'd0, sw_clean}, {24'd0, e.clean});
      end
    end
  end

  initial begin
    exp_t e;
    rst_n             = 1'b0;
    sw_raw            = 8'hFF;
    evt_bus.evt_ready = 1'b0;

    // 1: reset values, then all switches debounce high
    cycles(3);
    check("rst_clean", {24'd0, sw_clean}, 32'h00);
    check("rst_rise", {24'd0, sw_rise}, 32'h00);
    check("rst_fall", {24'd0, sw_fall}, 32'h00);
    check("rst_valid", {31'd0, evt_bus.evt_valid}, 32'd0);
    check("rst_mask", {24'd0, evt_bus.evt_mask}, 32'h00);
    check("rst_bits", {24'd0, evt_bus.evt_bits}, 32'h00);
    e.rise  = 8'hFF;
    e.fall  = 8'h00;
    e.clean = 8'hFF;
    sb.push_back(e);
    rst_n = 1'b1;
    #1;
    check("release_clean", {24'd0, sw_clean}, 32'h00);
    wait_pulse("s1_latency", 31, 41);
    @(negedge clk);
    check("s1_rise_one_cycle", {24'd0, sw_rise}, 32'h00);
    check("s1_valid", {31'd0, evt_bus.evt_valid}, 32'd1);
    check("s1_mask", {24'd0, evt_bus.evt_mask}, 32'hFF);
    evt_bus.evt_ready = 1'b1;
    @(negedge clk);
    evt_bus.evt_ready = 1'b0;
    check("s1_acc_valid", {31'd0, evt_bus.evt_valid}, 32'd0);
    check("s1_acc_mask", {24'd0, evt_bus.evt_mask}, 32'h00);

    // all low, then 2: bit 3 rises and is held
    drive(8'h00, 8'h00, 8'hFF);
    wait_pulse("s2_fall_latency", 32, 42);
    accept_event("s2a", 8'hFF, 8'h00);
    drive(8'h08, 8'h08, 8'h00);
    wait_pulse("s2_latency", 32, 42);
    accept_event("s2", 8'h08, 8'h08);

    // 3: bounce on bit 3 must yield a single late rise
    drive(8'h00, 8'h00, 8'h08);
    wait_pulse("s3_fall_latency", 32, 42);
    accept_event("s3a", 8'h08, 8'h00);
    sw_raw = 8'h08;
    cycles(25);
    sw_raw = 8'h00;
    cycles(15);
    check("s3_no_early_clean", {24'd0, sw_clean}, 32'h00);
    drive(8'h08, 8'h08, 8'h00);
    wait_pulse("s3_latency", 32, 42);
    accept_event("s3", 8'h08, 8'h08);
    cycles(50);

    // 4: three edges merge into one pending event
    drive(8'h09, 8'h01, 8'h00);
    wait_pulse("s4_b0_rise", 32, 42);
    drive(8'h0B, 8'h02, 8'h00);
    wait_pulse("s4_b1_rise", 32, 42);
    drive(8'h0A, 8'h00, 8'h01);
    wait_pulse("s4_b0_fall", 32, 42);
    accept_event("s4", 8'h03, 8'h0A);

    // 5: accept coincides with a new fall on bit 4
    drive(8'h0E, 8'h04, 8'h00);
    wait_pulse("s5_b2_rise", 32, 42);
    drive(8'h1E, 8'h10, 8'h00);
    wait_pulse("s5_b4_rise", 32, 42);
    drive(8'h0E, 8'h00, 8'h10);
    wait_pulse("s5_b4_fall", 32, 42);
    evt_bus.evt_ready = 1'b1;
    @(negedge clk);
    evt_bus.evt_ready = 1'b0;
    check("s5_valid_kept", {31'd0, evt_bus.evt_valid}, 32'd1);
    check("s5_mask_new_only", {24'd0, evt_bus.evt_mask}, 32'h10);
    check("s5_bits", {24'd0, evt_bus.evt_bits}, 32'h0E);
    evt_bus.evt_ready = 1'b1;
    @(negedge clk);
    evt_bus.evt_ready = 1'b0;
    check("s5_idle_valid", {31'd0, evt_bus.evt_valid}, 32'd0);

    // 6: reset while bit 6 is mid-debounce and an event is pending
    drive(8'h2E, 8'h20, 8'h00);
    wait_pulse("s6_b5_rise", 32, 42);
    sw_raw = 8'h6E;
    cycles(32);
    rst_n = 1'b0;
    #1;
    check("s6_rst_clean", {24'd0, sw_clean}, 32'h00);
    check("s6_rst_rise", {24'd0, sw_rise}, 32'h00);
    check("s6_rst_fall", {24'd0, sw_fall}, 32'h00);
    check("s6_rst_valid", {31'd0, evt_bus.evt_valid}, 32'd0);
    check("s6_rst_mask", {24'd0, evt_bus.evt_mask}, 32'h00);
    check("s6_rst_bits", {24'd0, evt_bus.evt_bits}, 32'h00);
    cycles(2);
    e.rise  = 8'h6E;
    e.fall  = 8'h00;
    e.clean = 8'h6E;
    sb.push_back(e);
    rst_n = 1'b1;
    wait_pulse("s6_restart_latency", 31, 41);
    accept_event("s6", 8'h6E, 8'h6E);
    cycles(20);

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
